fb_line_responder: RTL
======================

# fb_line_responder

Memory-side responder for the line-buffer fill path: services the 1536-bit line read/write requests issued by the fill engine (read_enable / write_enable / address / write_data / read_data) against a 32-bit synchronous frame-buffer SRAM. Each request is serialized into 48 word accesses; a one-cycle done pulse marks completion. Sits between the fill wrapper's memory port and the frame-buffer SRAM macro.

## Interface
- LINE_W, 1536, bits per line request
- WORD_W, 32, SRAM data width; WORDS = LINE_W/WORD_W = 48
- ADDR_W, 24, line address width
- IDX_W, 6, word-index width; SRAM word address = {address, idx}, stride 64, words 48..63 of each stride unused

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- read_enable  in  1  line read request, sampled in IDLE only
- write_enable  in  1  line write request, sampled in IDLE only
- address  in  ADDR_W  line address, latched at acceptance
- write_data  in  LINE_W  line to write, latched at acceptance; word k = bits [32k+31:32k]
- read_data  out  LINE_W  assembled line, word k in bits [32k+31:32k]
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W+IDX_W  SRAM word address
- sram_wdata  out  WORD_W  SRAM write word
- sram_we  out  1  SRAM write strobe
- sram_re  out  1  SRAM read strobe
- sram_rdata  in  WORD_W  SRAM read word, valid the cycle after sram_re

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: write_enable=1 → WRITE (write wins if both high; the read is dropped, not queued); else read_enable=1 → READ. Latch address, write_data; idx←0.
- WRITE: sram_we=1, sram_addr={addr_q, idx}, sram_wdata=word idx of latched line; idx++ each cycle; at idx=47 → IDLE, done←1.
- READ: sram_re=1, sram_addr={addr_q, idx}; idx++; at idx=47 → DRAIN. Word returned for idx k is written into read_data slice k the cycle after issue (capture pointer = idx delayed one cycle).
- DRAIN: capture word 47, → IDLE, done←1.
- Enables while busy are ignored; requester must hold or re-assert after done.
- read_data is written in place during a read; valid from the done cycle until the next read's first capture. Writes never modify read_data.
- sram_addr, sram_wdata driven 0 whenever the corresponding strobe is low.

## Timing
- Reset: state IDLE, idx 0, busy 0, done 0, sram_we 0, sram_re 0, sram_addr 0, sram_wdata 0, read_data 0.
- Cycle 0 = accepting edge. Write: strobes in cycles 1–48, done high in cycle 49. Read: strobes in cycles 1–48, DRAIN in cycle 49, done in cycle 50.
- busy high exactly while state ≠ IDLE; done and busy never both high.
- A request present in the done cycle is accepted at that cycle's closing edge (back-to-back, zero bubble).
- Reset mid-operation: immediate abort, no done, read_data cleared, no further SRAM strobes.
- idx never exceeds 47; word addresses 48..63 of a stride never issued.

## Structure
- Shared package gpu_mem_pkg: LINE_W, WORD_W, WORDS_PER_LINE (48), IDX_W, state enum fb_state_t (IDLE, WRITE, READ, DRAIN).
- One sub-module: mem_word_counter (IDX_W-bit clear/enable counter with terminal flag at WORDS_PER_LINE-1), shared with future line-transfer blocks.

## Test plan
- Reset then idle: all outputs 0; no strobes for 100 cycles with enables low.
- Write address 0x000012, write_data word k = 0xA5000000+k → 48 sram_we cycles, addresses 0x480..0x4AF, matching words, done in cycle 49, busy 48 cycles.
- Read address 0x000003, SRAM model returns 0x1000+word-address → read_data word k = 0x10C0+k, done in cycle 50.
- Both enables high in IDLE → write only, no sram_re; enables pulsed during busy → ignored, exactly one done.
- Back-to-back: read request held through done cycle → second read starts next cycle, no idle bubble, two done pulses 50 cycles apart.
- n_rst low at cycle 20 of a read → strobes stop immediately, read_data 0, no done; fresh write after release completes normally.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared constants and state encoding for the frame-buffer line transfer blocks.
package gpu_mem_pkg;
  localparam int LINE_W         = 1536;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int IDX_W          = 6;
  localparam int ADDR_W         = 24;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} fb_state_t;
endpackage

// File: rtl/mem_word_counter.sv
// Word-index counter for line transfers; wraps to 0 after the last word of a line.
module mem_word_counter
  import gpu_mem_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             last
);
  logic [IDX_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == IDX_W'(WORDS_PER_LINE - 1));
  assign cnt  = cnt_q;

  // Wrapping on the terminal word keeps the unused stride slots unreachable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : cnt_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fb_line_responder.sv
// Serializes 1536-bit line reads/writes into 48 word accesses on a 32-bit
// synchronous frame-buffer SRAM and signals completion with a done pulse.
module fb_line_responder
  import gpu_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    read_enable,
  input  logic                    write_enable,
  input  logic [ADDR_W-1:0]       address,
  input  logic [LINE_W-1:0]       write_data,
  output logic [LINE_W-1:0]       read_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W+IDX_W-1:0] sram_addr,
  output logic [WORD_W-1:0]       sram_wdata,
  output logic                    sram_we,
  output logic                    sram_re,
  input  logic [WORD_W-1:0]       sram_rdata
);
  fb_state_t                                  state_q, state_d;
  logic [ADDR_W-1:0]                          addr_q, addr_d;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]      wdata_q, wdata_d;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]      rdata_q, rdata_d;
  logic                                       cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0]                           cap_idx_q, cap_idx_d;
  logic                                       done_q, done_d;
  logic [IDX_W-1:0]                           idx;
  logic                                       idx_last, cnt_clr, cnt_en;

  mem_word_counter u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (idx),
    .last  (idx_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    cap_vld_d = 1'b0;
    cap_idx_d = idx;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read is dropped, not queued.
        if (write_enable || read_enable) begin
          addr_d  = address;
          wdata_d = write_data;
          cnt_clr = 1'b1;
          state_d = write_enable ? WRITE : READ;
        end
      end
      WRITE: begin
        cnt_en = 1'b1;
        if (idx_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        cnt_en    = 1'b1;
        cap_vld_d = 1'b1;
        if (idx_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // SRAM read data lags the strobe by one cycle, so capture uses the delayed index.
    if (cap_vld_q) rdata_d[cap_idx_q] = sram_rdata;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sram_we    = (state_q == WRITE);
  assign sram_re    = (state_q == READ);
  assign sram_addr  = (sram_we || sram_re) ? {addr_q, idx} : '0;
  assign sram_wdata = sram_we ? wdata_q[idx] : '0;
  assign read_data  = rdata_q;
endmodule
